// File: rtl/mul_iter.sv
// Iterative 32x32 multiplier (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), 8 multiplier bits
// per cycle with early termination, followed by optional accumulate/long cycles.
module mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] acc_in,
  input  logic        accumulate,
  input  logic        long_mul,
  input  logic        signed_mul,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        flag_n,
  output logic        flag_z
);

  // state | meaning
  // IDLE  | waiting for start; result/flags hold last completion
  // STEP  | one 8-bit multiplier slice per cycle, m cycles
  // EXTRA | accumulate / long-result cycles, e cycles
  typedef enum logic [1:0] {IDLE, STEP, EXTRA} state_t;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] addend_q, addend_d;
  logic [2:0]  steps_q, steps_d;
  logic [1:0]  extra_q, extra_d;
  logic        accum_q, accum_d;
  logic        long_q, long_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic [63:0] result_q, result_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_z_q, flag_z_d;

  logic        allow_ones;
  logic [2:0]  m_start;
  logic        neg_start;
  logic [63:0] pp;
  logic [63:0] step_sum;
  logic [63:0] extra_sum;
  logic        last_step;
  logic        fin_en;
  logic [63:0] fin_val;

  // Step count: stop once the remaining multiplier bits are pure sign/zero fill.
  // neg_start marks a remaining fill of ones, which is folded in as a final subtraction.
  always_comb begin
    allow_ones = signed_mul | ~long_mul;
    m_start    = 3'd4;
    neg_start  = long_mul & signed_mul & op_b[31];
    if (op_b[31:8] == 24'd0) begin
      m_start   = 3'd1;
      neg_start = 1'b0;
    end else if (allow_ones && (&op_b[31:8])) begin
      m_start   = 3'd1;
      neg_start = 1'b1;
    end else if (op_b[31:16] == 16'd0) begin
      m_start   = 3'd2;
      neg_start = 1'b0;
    end else if (allow_ones && (&op_b[31:16])) begin
      m_start   = 3'd2;
      neg_start = 1'b1;
    end else if (op_b[31:24] == 8'd0) begin
      m_start   = 3'd3;
      neg_start = 1'b0;
    end else if (allow_ones && (&op_b[31:24])) begin
      m_start   = 3'd3;
      neg_start = 1'b1;
    end
  end

  assign last_step = (steps_q == 3'd1);
  assign pp        = mcand_q * {56'd0, mplier_q[7:0]};
  assign step_sum  = acc_q + pp - ((last_step && neg_q) ? (mcand_q << 8) : 64'd0);
  assign extra_sum = accum_q ? (acc_q + addend_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    addend_d = addend_q;
    steps_d  = steps_q;
    extra_d  = extra_q;
    accum_d  = accum_q;
    long_d   = long_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    fin_en   = 1'b0;
    fin_val  = 64'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = (long_mul && signed_mul) ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
          mplier_d = op_b;
          acc_d    = 64'd0;
          if (!accumulate) addend_d = 64'd0;
          else if (long_mul) addend_d = acc_in;
          else addend_d = {32'd0, acc_in[31:0]};
          steps_d  = m_start;
          extra_d  = {1'b0, long_mul} + {1'b0, accumulate};
          accum_d  = accumulate;
          long_d   = long_mul;
          neg_d    = neg_start;
          state_d  = STEP;
        end
      end
      STEP: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 8;
        mplier_d = mplier_q >> 8;
        steps_d  = steps_q - 3'd1;
        if (last_step) begin
          if (extra_q == 2'd0) begin
            fin_en  = 1'b1;
            fin_val = step_sum;
          end else begin
            state_d = EXTRA;
          end
        end
      end
      EXTRA: begin
        acc_d   = extra_sum;
        accum_d = 1'b0;
        extra_d = extra_q - 2'd1;
        if (extra_q == 2'd1) begin
          fin_en  = 1'b1;
          fin_val = extra_sum;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_en) begin
      state_d  = IDLE;
      done_d   = 1'b1;
      result_d = long_q ? fin_val : {32'd0, fin_val[31:0]};
      flag_n_d = long_q ? fin_val[63] : fin_val[31];
      flag_z_d = long_q ? (fin_val == 64'd0) : (fin_val[31:0] == 32'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      addend_q <= 64'd0;
      steps_q  <= 3'd0;
      extra_q  <= 2'd0;
      accum_q  <= 1'b0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 64'd0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      addend_q <= addend_d;
      steps_q  <= steps_d;
      extra_q  <= extra_d;
      accum_q  <= accum_d;
      long_q   <= long_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

endmodule
